// File: rtl/exc_pkg.sv
// rtl/exc_pkg.sv - shared state and cause encodings for the exception sequencer
package exc_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        RUN     = 3'd0,
        FLUSH   = 3'd1,
        VECTOR  = 3'd2,
        HANDLER = 3'd3,
        RESTORE = 3'd4,
        HALT    = 3'd5
    } state_t;

    // Cause codes, lower non-zero value = higher priority
    localparam logic [2:0] CAUSE_NONE = 3'd0;
    localparam logic [2:0] CAUSE_PC   = 3'd1;
    localparam logic [2:0] CAUSE_OVF  = 3'd2;
    localparam logic [2:0] CAUSE_DIV  = 3'd3;
    localparam logic [2:0] CAUSE_ILL  = 3'd4;

endpackage

// File: rtl/exc_prio_enc.sv
// rtl/exc_prio_enc.sv - fault source priority encoder
// Ports:
//   pc_exception  in   PC fault for the instruction at EX/MEM
//   alu_status    in   ALU flags; [6] overflow, [3] div-by-zero, [2] illegal op
//   trigger       out  any recognised fault present
//   cause         out  code of the highest-priority fault (CAUSE_NONE if none)
module exc_prio_enc
    import exc_pkg::*;
(
    input  logic       pc_exception,
    input  logic [7:0] alu_status,
    output logic       trigger,
    output logic [2:0] cause
);

    // Same bit selection as the writeback guard, so both see identical faults
    logic ovf;
    logic div_zero;
    logic illegal;
    logic unused_alu_bits;

    assign ovf      = alu_status[6];
    assign div_zero = alu_status[3];
    assign illegal  = alu_status[2];

    assign unused_alu_bits = ^{alu_status[7], alu_status[5:4], alu_status[1:0]};

    assign trigger = pc_exception | ovf | div_zero | illegal;

    always_comb begin
        cause = CAUSE_NONE;
        if (pc_exception)  cause = CAUSE_PC;
        else if (ovf)      cause = CAUSE_OVF;
        else if (div_zero) cause = CAUSE_DIV;
        else if (illegal)  cause = CAUSE_ILL;
    end

endmodule

// File: rtl/exception_ctrl.sv
// rtl/exception_ctrl.sv - precise exception entry/return sequencer
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   pc_exception  PC fault at EX/MEM
//   alu_status    ALU flags ([6],[3],[2] are fault sources)
//   cur_pc        PC of the instruction at EX/MEM
//   eret          decoded ERET at EX/MEM
//   flush, stall  pipeline register clear / freeze
//   pc_redirect   PC mux takes redirect_pc this cycle
//   redirect_pc   redirect target (0 when not redirecting)
//   epc, cause    captured faulting PC and cause code
//   in_handler    handler executing
//   halted        double fault, core stopped until reset
module exception_ctrl
    import exc_pkg::*;
#(
    parameter int              PC_W         = 32,
    parameter logic [PC_W-1:0] HANDLER_ADDR = 'h80,
    parameter int              FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pc_exception,
    input  logic [7:0]      alu_status,
    input  logic [PC_W-1:0] cur_pc,
    input  logic            eret,
    output logic            flush,
    output logic            stall,
    output logic            pc_redirect,
    output logic [PC_W-1:0] redirect_pc,
    output logic [PC_W-1:0] epc,
    output logic [2:0]      cause,
    output logic            in_handler,
    output logic            halted
);

    localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic             trigger;
    logic [2:0]       fault_cause;

    exc_prio_enc u_prio (
        .pc_exception (pc_exception),
        .alu_status   (alu_status),
        .trigger      (trigger),
        .cause        (fault_cause)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (trigger) state_next = FLUSH;
            // Last flush cycle when the counter reaches 1
            FLUSH:   if (cnt <= CNT_W'(1)) state_next = VECTOR;
            VECTOR:  state_next = HANDLER;
            // A fault inside the handler outranks a simultaneous eret
            HANDLER: begin
                if (trigger)   state_next = HALT;
                else if (eret) state_next = RESTORE;
            end
            RESTORE: state_next = RUN;
            HALT:    state_next = HALT;
            default: state_next = RUN;
        endcase
    end

    // Flush counter and EPC/cause capture
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            epc   <= '0;
            cause <= CAUSE_NONE;
        end else begin
            case (state)
                RUN: begin
                    if (trigger) begin
                        epc   <= cur_pc;
                        cause <= fault_cause;
                        cnt   <= CNT_W'(FLUSH_CYCLES);
                    end
                end
                FLUSH: begin
                    if (cnt != '0) cnt <= cnt - CNT_W'(1);
                end
                HANDLER: begin
                    if (trigger) begin
                        epc   <= cur_pc;
                        cause <= fault_cause;
                    end
                end
                RESTORE: cause <= CAUSE_NONE;
                default: ;
            endcase
        end
    end

    always_comb begin
        flush       = 1'b0;
        stall       = 1'b0;
        pc_redirect = 1'b0;
        redirect_pc = '0;
        in_handler  = 1'b0;
        halted      = 1'b0;
        case (state)
            FLUSH: begin
                flush = 1'b1;
                stall = 1'b1;
            end
            VECTOR: begin
                flush       = 1'b1;
                pc_redirect = 1'b1;
                redirect_pc = HANDLER_ADDR;
            end
            HANDLER: in_handler = 1'b1;
            RESTORE: begin
                flush       = 1'b1;
                pc_redirect = 1'b1;
                redirect_pc = epc;
            end
            HALT: begin
                stall  = 1'b1;
                halted = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_exception_ctrl.sv
// tb/tb_exception_ctrl.sv - scoreboard bench for exception_ctrl
module tb_exception_ctrl;

    localparam int F = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pc_exception = 1'b0;
    logic [7:0]  alu_status = '0;
    logic [31:0] cur_pc = '0;
    logic        eret = 1'b0;
    logic        flush, stall, pc_redirect, in_handler, halted;
    logic [31:0] redirect_pc, epc;
    logic [2:0]  cause;

    exception_ctrl #(.PC_W(32), .HANDLER_ADDR(32'h80), .FLUSH_CYCLES(F)) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_exception (pc_exception),
        .alu_status   (alu_status),
        .cur_pc       (cur_pc),
        .eret         (eret),
        .flush        (flush),
        .stall        (stall),
        .pc_redirect  (pc_redirect),
        .redirect_pc  (redirect_pc),
        .epc          (epc),
        .cause        (cause),
        .in_handler   (in_handler),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int          edge_no;
        logic [71:0] out;
    } exp_t;

    exp_t sb[$];
    int   edge_cnt = 0;
    int   checks = 0;
    int   failures = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Reference model: exception sequence tracked as cycles elapsed since the
    // trigger edge (1..F flushing, F+1 vectoring), plus handler/restore/halt flags.
    int          m_age = 0;
    bit          m_hdl = 0;
    bit          m_rest = 0;
    bit          m_halt = 0;
    logic [31:0] m_epc = '0;
    logic [2:0]  m_cause = '0;

    function automatic logic [2:0] fault_code(input logic px, input logic [7:0] a);
        if (px)   return 3'd1;
        if (a[6]) return 3'd2;
        if (a[3]) return 3'd3;
        if (a[2]) return 3'd4;
        return 3'd0;
    endfunction

    task automatic step(input logic r, input logic px, input logic [7:0] a,
                        input logic [31:0] pc, input logic e);
        exp_t        x;
        logic [2:0]  fc;
        logic        fl, st, rd;
        logic [31:0] rpc;
        @(negedge clk);
        rst = r; pc_exception = px; alu_status = a; cur_pc = pc; eret = e;
        fc = fault_code(px, a);
        if (r) begin
            m_age = 0; m_hdl = 0; m_rest = 0; m_halt = 0; m_epc = '0; m_cause = '0;
        end else if (m_halt) begin
        end else if (m_rest) begin
            m_rest = 0; m_cause = '0;
        end else if (m_age > 0) begin
            m_age++;
            if (m_age > F + 1) begin m_age = 0; m_hdl = 1; end
        end else if (m_hdl) begin
            if (fc != 0) begin
                m_hdl = 0; m_halt = 1; m_epc = pc; m_cause = fc;
            end else if (e) begin
                m_hdl = 0; m_rest = 1;
            end
        end else if (fc != 0) begin
            m_age = 1; m_epc = pc; m_cause = fc;
        end
        fl  = (m_age >= 1) || m_rest;
        st  = (m_age >= 1 && m_age <= F) || m_halt;
        rd  = (m_age == F + 1) || m_rest;
        rpc = (m_age == F + 1) ? 32'h80 : (m_rest ? m_epc : 32'h0);
        x.edge_no = edge_cnt + 1;
        x.out = {fl, st, rd, rpc, m_epc, m_cause, m_hdl, m_halt};
        sb.push_back(x);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 8'h00, 32'h0, 0);
    endtask

    exp_t        mon_e;
    logic [71:0] mon_got;

    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].edge_no <= edge_cnt) begin
            mon_e   = sb.pop_front();
            mon_got = {flush, stall, pc_redirect, redirect_pc, epc, cause, in_handler, halted};
            checks++;
            if (mon_got !== mon_e.out) begin
                failures++;
                $display("FAIL outputs edge=%0d got={fl,st,rd,rpc,epc,cause,hdl,halt}=%h required=%h",
                         mon_e.edge_no, mon_got, mon_e.out);
            end
        end
    end

    initial begin
        // Reset state
        step(1, 0, 8'h00, 32'h0, 0);
        step(1, 0, 8'h00, 32'h0, 0);
        // Ignored events in RUN
        step(0, 0, 8'h00, 32'h500, 1);
        step(0, 0, 8'h01, 32'h504, 0);
        step(0, 0, 8'hB3, 32'h508, 0);
        // Overflow entry, with a fault during flush that must be ignored
        step(0, 0, 8'h40, 32'h1004, 0);
        step(0, 0, 8'h40, 32'hDEAD, 0);
        idle(4);
        // Return
        step(0, 0, 8'h00, 32'h0, 1);
        idle(3);
        // Priority
        step(0, 1, 8'h4C, 32'h2000, 0);
        idle(5);
        // Double fault with simultaneous eret, then HALT held
        step(0, 0, 8'h08, 32'h84, 1);
        idle(3);
        step(0, 1, 8'h44, 32'h90, 1);
        idle(2);
        step(1, 0, 8'h00, 32'h0, 0);
        // Reset in the first flush cycle, then a full re-entry
        step(0, 0, 8'h04, 32'h3000, 0);
        step(1, 0, 8'h00, 32'h0, 0);
        step(0, 0, 8'h08, 32'h3010, 0);
        idle(6);
        step(0, 0, 8'h00, 32'h0, 1);
        idle(2);
        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            logic        r, px, e;
            logic [7:0]  a;
            r  = ($urandom_range(0, 39) == 0);
            px = ($urandom_range(0, 9) == 0);
            a  = 8'($urandom);
            if ($urandom_range(0, 3) != 0) a = a & 8'hB3;
            e  = ($urandom_range(0, 3) == 0);
            step(r, px, a, $urandom, e);
        end
        @(posedge clk);
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d pending required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/exception_ctrl.md
# exception_ctrl

Sequencer for precise exception entry and return in the MIPS core. Watches the same fault sources that gate MemWrite/Mem2Reg (PC fault, ALU status bits 6/3/2), captures EPC and cause, and drives a timed pipeline flush and redirect to the handler. It waits for ERET to restore the faulting PC, and halts the core on a fault raised inside the handler (double fault). Sits beside the writeback guard in the EX/MEM boundary and feeds the PC-select mux and pipeline-register flush/stall controls.

## Interface
- PC_W, 32, PC/EPC width
- HANDLER_ADDR, 32'h0000_0080, exception vector (PC_W bits)
- FLUSH_CYCLES, 2, cycles flush is held before vectoring (must be ≥1)

- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- pc_exception  in  1  PC fault (misaligned/invalid fetch) for the instruction at EX/MEM
- alu_status  in  8  ALU flags; [6] overflow, [3] divide-by-zero, [2] illegal op; other bits ignored
- cur_pc  in  PC_W  PC of the instruction at EX/MEM
- eret  in  1  decoded ERET at EX/MEM
- flush  out  1  clear IF/ID, ID/EX, EX/MEM valid bits
- stall  out  1  freeze PC and pipeline registers
- pc_redirect  out  1  PC mux selects redirect_pc this cycle
- redirect_pc  out  PC_W  redirect target
- epc  out  PC_W  captured faulting PC
- cause  out  3  captured cause code
- in_handler  out  1  handler executing
- halted  out  1  double fault, core stopped

## Operation
- Trigger = pc_exception | alu_status[6] | alu_status[3] | alu_status[2].
- Cause priority: pc_exception=1 > overflow=2 > div-zero=3 > illegal=4; 0 = none. Only the highest-priority source is recorded.
- States: RUN, FLUSH, VECTOR, HANDLER, RESTORE, HALT.
- RUN: on trigger, latch epc←cur_pc and cause, load counter←FLUSH_CYCLES, go to FLUSH. An eret in RUN is ignored.
- FLUSH: flush=1, stall=1. Decrement the counter each cycle. At 1, go to VECTOR. Triggers are ignored (flushed instructions).
- VECTOR: pc_redirect=1, redirect_pc=HANDLER_ADDR, flush=1, one cycle, then HANDLER.
- HANDLER: in_handler=1. A trigger goes to HALT, with epc/cause overwritten with the new fault. Otherwise eret goes to RESTORE. When trigger and eret arrive together, trigger wins and the next state is HALT.
- RESTORE: pc_redirect=1, redirect_pc=epc, flush=1, one cycle, then RUN. cause is cleared to 0; epc is held.
- HALT: stall=1, halted=1, cause/epc frozen. Exit only on rst.
- In every state other than those listed above, the outputs flush, stall and pc_redirect are 0.
- Counter width is $clog2(FLUSH_CYCLES+1). It does not wrap.

## Timing
- Reset: state RUN. All outputs are 0: flush, stall, pc_redirect, redirect_pc, epc, cause, in_handler, halted.
- rst mid-operation returns to RUN next edge from any state. The counter is cleared.
- Outputs are decoded from registered state (Moore). flush asserts the cycle after the trigger edge.
- Latency from trigger cycle to pc_redirect to the handler is FLUSH_CYCLES+1 cycles. Default 3.
- Latency from eret to pc_redirect to EPC is 1 cycle.
- redirect_pc is 0 when pc_redirect=0.

## Structure
- Package exc_pkg: state enum (RUN, FLUSH, VECTOR, HANDLER, RESTORE, HALT) and cause localparams CAUSE_NONE..CAUSE_ILL (3 bits).
- One combinational sub-module, exc_prio_enc: takes pc_exception and alu_status, produces trigger and cause. It shares the bit selection with the existing writeback guard so both agree on fault sources.
- Top: FSM, flush counter, EPC/cause registers.

## Test plan
- Overflow entry: alu_status=8'h40, cur_pc=32'h0000_1004 in RUN. Expect flush/stall high 2 cycles, then pc_redirect with redirect_pc=32'h80. Expect epc=32'h1004 and cause=2.
- Priority: pc_exception=1 and alu_status=8'h4C in the same cycle. Expect cause=1.
- Return: eret in HANDLER. Expect a 1-cycle pc_redirect with redirect_pc=epc and flush=1, then RUN with cause=0 and in_handler=0.
- Double fault: in HANDLER, assert alu_status=8'h08 together with eret, cur_pc=32'h84. Expect HALT, halted=1, stall=1, epc=32'h84, cause=3. Expect HALT held until rst.
- Ignored events: eret in RUN produces no output change. alu_status=8'h40 during FLUSH does not alter epc/cause. alu_status=8'h01 never triggers.
- Reset mid-FLUSH: rst in the first FLUSH cycle. Next cycle RUN, all outputs 0. A new trigger re-enters with full FLUSH_CYCLES.
